// File: rtl/cp0_exception_sequencer.sv
// -----------------------------------------------------------------------------
// cp0_exception_sequencer
//
// Control FSM sitting between the writeback stage and coprocessor 0. It spots
// a committing exception, a pending interrupt or an ERET in WB, sends one
// commit strobe to CP0, and flushes the pipeline for a fixed drain window.
// It then presents a redirect PC to IF and holds it until IF accepts it.
// This block is the only source of the exception_valid and eret_flush strobes
// that CP0 sees.
//
// Ports
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   wb_valid                : WB holds a committing instruction
//   wb_exception_valid/code : synchronous exception raised by the WB instruction
//   wb_eret                 : WB instruction is ERET
//   wb_pc, wb_in_delay_slot : PC and delay-slot flag of the WB instruction
//   cp0_status/cause/epc    : current CP0 Status, Cause and EPC
//   cp0_exception_valid     : one-cycle exception commit strobe
//   cp0_eret_flush          : one-cycle ERET strobe
//   cp0_exception_code/address/in_delay_slot : fields latched at the event
//   pipeline_flush          : kill every instruction in IF..WB
//   redirect_valid/pc       : fetch redirect presented to IF
//   if_ready                : IF accepts the redirect this cycle
//   busy                    : sequencer is not idle
// -----------------------------------------------------------------------------
module cp0_exception_sequencer #(
   parameter logic [31:0] EXCEPTION_VECTOR   = 32'hbfc00380,
   parameter int unsigned FLUSH_CYCLES       = 2,
   parameter logic [4:0]  INT_EXCEPTION_CODE = 5'h00
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wb_valid,
   input  logic        wb_exception_valid,
   input  logic [4:0]  wb_exception_code,
   input  logic        wb_eret,
   input  logic [31:0] wb_pc,
   input  logic        wb_in_delay_slot,
   input  logic [31:0] cp0_status,
   input  logic [31:0] cp0_cause,
   input  logic [31:0] cp0_epc,
   output logic        cp0_exception_valid,
   output logic        cp0_eret_flush,
   output logic [4:0]  cp0_exception_code,
   output logic [31:0] cp0_exception_address,
   output logic        cp0_in_delay_slot,
   output logic        pipeline_flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        if_ready,
   output logic        busy
);

   // The counter is preloaded with FLUSH_CYCLES-1 so that the DRAIN state,
   // which exits when the counter reads zero, lasts exactly FLUSH_CYCLES cycles.
   localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COMMIT   = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_REDIRECT = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        is_eret_q, is_eret_d;
   logic [4:0]  code_q, code_d;
   logic [31:0] addr_q, addr_d;
   logic        ds_q, ds_d;
   logic [31:0] rpc_q, rpc_d;
   logic        exc_valid_q, exc_valid_d;
   logic        eret_flush_q, eret_flush_d;
   logic        flush_q, flush_d;
   logic        rvalid_q, rvalid_d;
   logic        busy_q, busy_d;
   logic        int_pend_s;

   // Interrupt pending: enabled, not already in exception level, and at least one unmasked IP line.
   assign int_pend_s = cp0_status[0] & ~cp0_status[1] & (|(cp0_status[15:8] & cp0_cause[15:8]));

   // Next-state, latched fields and next registered output values.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_eret_d = is_eret_q;
      code_d    = code_q;
      addr_d    = addr_q;
      ds_d      = ds_q;
      rpc_d     = rpc_q;

      case (state_q)
         ST_IDLE: begin
            if (wb_valid && (int_pend_s || wb_exception_valid || wb_eret)) begin
               state_d = ST_COMMIT;
               addr_d  = wb_pc;
               ds_d    = wb_in_delay_slot;
               // Interrupt outranks a synchronous exception, which outranks ERET.
               if (int_pend_s) begin
                  is_eret_d = 1'b0;
                  code_d    = INT_EXCEPTION_CODE;
               end else if (wb_exception_valid) begin
                  is_eret_d = 1'b0;
                  code_d    = wb_exception_code;
               end else begin
                  is_eret_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_COMMIT: begin
            cnt_d   = DRAIN_LOAD;
            state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_REDIRECT;
               // EPC is sampled only now so that any earlier MTC0 EPC write has landed.
               if (is_eret_q) begin
                  rpc_d = cp0_epc;
               end else begin
                  rpc_d = EXCEPTION_VECTOR;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_REDIRECT: begin
            if (if_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_REDIRECT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered decodes of the state being entered.
      exc_valid_d  = (state_d == ST_COMMIT) && !is_eret_d;
      eret_flush_d = (state_d == ST_COMMIT) && is_eret_d;
      flush_d      = (state_d == ST_COMMIT) || (state_d == ST_DRAIN);
      rvalid_d     = (state_d == ST_REDIRECT);
      busy_d       = (state_d != ST_IDLE);
   end

   // State, latched fields and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         is_eret_q    <= 1'b0;
         code_q       <= 5'd0;
         addr_q       <= 32'd0;
         ds_q         <= 1'b0;
         rpc_q        <= 32'd0;
         exc_valid_q  <= 1'b0;
         eret_flush_q <= 1'b0;
         flush_q      <= 1'b0;
         rvalid_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         is_eret_q    <= is_eret_d;
         code_q       <= code_d;
         addr_q       <= addr_d;
         ds_q         <= ds_d;
         rpc_q        <= rpc_d;
         exc_valid_q  <= exc_valid_d;
         eret_flush_q <= eret_flush_d;
         flush_q      <= flush_d;
         rvalid_q     <= rvalid_d;
         busy_q       <= busy_d;
      end
   end

   assign cp0_exception_valid   = exc_valid_q;
   assign cp0_eret_flush        = eret_flush_q;
   assign cp0_exception_code    = code_q;
   assign cp0_exception_address = addr_q;
   assign cp0_in_delay_slot     = ds_q;
   assign pipeline_flush        = flush_q;
   assign redirect_valid        = rvalid_q;
   assign redirect_pc           = rpc_q;
   assign busy                  = busy_q;

endmodule

// File: tb/tb_cp0_exception_sequencer.sv
// -----------------------------------------------------------------------------
// Directed bench for cp0_exception_sequencer. Each scenario pushes the
// expected per-cycle output snapshot into a queue as stimulus is driven; each
// cycle, one entry is popped and compared against the DUT #1 after the edge.
// -----------------------------------------------------------------------------
module tb_cp0_exception_sequencer;

   localparam int          FLUSH = 2;
   localparam logic [31:0] VEC   = 32'hbfc00380;

   logic        clock = 1'b0;
   logic        reset;
   logic        wb_valid, wb_exception_valid, wb_eret, wb_in_delay_slot;
   logic [4:0]  wb_exception_code;
   logic [31:0] wb_pc, cp0_status, cp0_cause, cp0_epc;
   logic        cp0_exception_valid, cp0_eret_flush, cp0_in_delay_slot;
   logic [4:0]  cp0_exception_code;
   logic [31:0] cp0_exception_address, redirect_pc;
   logic        pipeline_flush, redirect_valid, if_ready, busy;

   cp0_exception_sequencer dut (
      .clock(clock), .reset(reset),
      .wb_valid(wb_valid), .wb_exception_valid(wb_exception_valid),
      .wb_exception_code(wb_exception_code), .wb_eret(wb_eret),
      .wb_pc(wb_pc), .wb_in_delay_slot(wb_in_delay_slot),
      .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
      .cp0_exception_valid(cp0_exception_valid), .cp0_eret_flush(cp0_eret_flush),
      .cp0_exception_code(cp0_exception_code),
      .cp0_exception_address(cp0_exception_address),
      .cp0_in_delay_slot(cp0_in_delay_slot), .pipeline_flush(pipeline_flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_ready(if_ready), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        exc;
      logic        eret;
      logic        code_chk;
      logic [4:0]  code;
      logic [31:0] addr;
      logic        ds;
      logic        flush;
      logic        rv;
      logic [31:0] rpc;
      logic        busy;
   } exp_t;

   exp_t        expq[$];
   int          checks = 0;
   int          passed = 0;
   int          fails  = 0;
   logic [4:0]  cur_code;
   logic [31:0] cur_addr, cur_rpc;
   logic        cur_ds;

   task automatic push(input bit exc, input bit eret, input bit flush,
                       input bit rv, input bit bsy, input bit force_code);
      exp_t e;
      e.exc = exc; e.eret = eret; e.code_chk = exc | force_code;
      e.code = cur_code; e.addr = cur_addr; e.ds = cur_ds;
      e.flush = flush; e.rv = rv; e.rpc = cur_rpc; e.busy = bsy;
      expq.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: advance, sample away from the edge, pop and compare.
   task automatic cyc();
      exp_t e;
      @(posedge clock);
      #1;
      checks++;
      assert (expq.size() != 0) passed++;
      else begin
         fails++;
         $error("FAIL queue_empty observed=%0d expected=nonzero", expq.size());
      end
      if (expq.size() != 0) begin
         e = expq.pop_front();
         chk("exc_valid",  32'(cp0_exception_valid),   32'(e.exc));
         chk("eret_flush", 32'(cp0_eret_flush),        32'(e.eret));
         chk("flush",      32'(pipeline_flush),        32'(e.flush));
         chk("redir_vld",  32'(redirect_valid),        32'(e.rv));
         chk("busy",       32'(busy),                  32'(e.busy));
         chk("address",    cp0_exception_address,      e.addr);
         chk("delay_slot", 32'(cp0_in_delay_slot),     32'(e.ds));
         chk("redir_pc",   redirect_pc,                e.rpc);
         if (e.code_chk) begin
            chk("code", 32'(cp0_exception_code), 32'(e.code));
         end
      end
   endtask

   task automatic clear_wb();
      wb_valid = 1'b0; wb_exception_valid = 1'b0; wb_eret = 1'b0;
      wb_exception_code = 5'd0; wb_pc = 32'd0; wb_in_delay_slot = 1'b0;
   endtask

   task automatic zero_cur();
      cur_code = 5'd0; cur_addr = 32'd0; cur_ds = 1'b0; cur_rpc = 32'd0;
   endtask

   // Full sequence after the caller has driven WB with the triggering event.
   task automatic seq(input bit eret_k, input logic [4:0] code, input logic [31:0] pc,
                      input bit ds, input logic [31:0] rpc, input int delay, input bit inject);
      cur_addr = pc; cur_ds = ds;
      if (!eret_k) cur_code = code;
      push(!eret_k, eret_k, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc();
      if (inject) begin
         // A second exception arriving while busy must be ignored.
         wb_valid = 1'b1; wb_exception_valid = 1'b1; wb_exception_code = 5'h0d;
         wb_pc = 32'h1234_5678; wb_in_delay_slot = ~ds;
      end else begin
         clear_wb();
      end
      for (int i = 0; i < FLUSH; i++) begin
         push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
         cyc();
         if (i == 0) clear_wb();
      end
      cur_rpc = rpc;
      for (int i = 0; i <= delay; i++) begin
         push(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         cyc();
         if_ready = (i == delay);
      end
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      if_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; if_ready = 1'b0;
      cp0_status = 32'd0; cp0_cause = 32'd0; cp0_epc = 32'd0;
      clear_wb();
      zero_cur();

      // Reset state
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
      reset = 1'b0;
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();

      // Syscall exception, IF ready at once
      wb_valid = 1'b1; wb_exception_valid = 1'b1; wb_exception_code = 5'h08;
      wb_pc = 32'hbfc00100; wb_in_delay_slot = 1'b0;
      seq(1'b0, 5'h08, 32'hbfc00100, 1'b0, VEC, 0, 1'b0);

      // ERET, IF stalls for 3 cycles
      cp0_epc = 32'hbfc00200;
      wb_valid = 1'b1; wb_eret = 1'b1; wb_pc = 32'hbfc00180;
      seq(1'b1, 5'd0, 32'hbfc00180, 1'b0, 32'hbfc00200, 3, 1'b0);

      // Interrupt beats a simultaneous ERET
      cp0_status = 32'h0000_0401; cp0_cause = 32'h0000_0400;
      wb_valid = 1'b1; wb_eret = 1'b1; wb_pc = 32'hbfc00300;
      seq(1'b0, 5'h00, 32'hbfc00300, 1'b0, VEC, 1, 1'b0);

      // EXL masks the interrupt: no event
      cp0_status = 32'h0000_0403;
      wb_valid = 1'b1; wb_pc = 32'h0000_4000;
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
      // Interrupt pending but no wb_valid: no event
      cp0_status = 32'h0000_0401;
      wb_valid = 1'b0;
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
      cp0_status = 32'd0; cp0_cause = 32'd0;
      clear_wb();

      // Exception beats a simultaneous ERET, delay slot set, second exception ignored
      wb_valid = 1'b1; wb_exception_valid = 1'b1; wb_eret = 1'b1;
      wb_exception_code = 5'h0c; wb_pc = 32'h8000_0010; wb_in_delay_slot = 1'b1;
      seq(1'b0, 5'h0c, 32'h8000_0010, 1'b1, VEC, 0, 1'b1);

      // Reset during DRAIN aborts the sequence
      wb_valid = 1'b1; wb_exception_valid = 1'b1; wb_exception_code = 5'h04;
      wb_pc = 32'h8000_0400; wb_in_delay_slot = 1'b0;
      cur_addr = 32'h8000_0400; cur_ds = 1'b0; cur_code = 5'h04;
      push(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); cyc();
      clear_wb();
      push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); cyc();
      reset = 1'b1;
      zero_cur();
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
      reset = 1'b0;
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();

      // Exception handled normally after the abort
      wb_valid = 1'b1; wb_exception_valid = 1'b1; wb_exception_code = 5'h0a;
      wb_pc = 32'h8000_0800; wb_in_delay_slot = 1'b1;
      seq(1'b0, 5'h0a, 32'h8000_0800, 1'b1, VEC, 2, 1'b0);

      checks++;
      assert (expq.size() == 0) passed++;
      else begin
         fails++;
         $error("FAIL queue_drained observed=%0d expected=0", expq.size());
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/cp0_exception_sequencer.md
Name: cp0_exception_sequencer

Overview:
- Control FSM between the writeback stage and coprocessor 0.
- Detects a committing exception, a pending interrupt or an ERET in WB, and issues a single-cycle commit strobe to CP0.
- Holds a pipeline flush for a fixed drain window, then presents a redirect PC to IF until IF accepts it.
- This block is the only source of the exception_valid and eret_flush strobes that CP0 sees.

Parameters:
- EXCEPTION_VECTOR, 32'hbfc00380, redirect target for exceptions and interrupts.
- FLUSH_CYCLES, 2, number of DRAIN cycles after COMMIT; legal range 1..15.
- INT_EXCEPTION_CODE, 5'h00, exception code reported for interrupts.

Ports:
- clock  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- wb_valid  in  1  WB holds a committing instruction this cycle.
- wb_exception_valid  in  1  WB instruction raised a synchronous exception.
- wb_exception_code  in  5  code for wb_exception_valid.
- wb_eret  in  1  WB instruction is ERET.
- wb_pc  in  32  PC of the WB instruction.
- wb_in_delay_slot  in  1  WB instruction sits in a branch delay slot.
- cp0_status  in  32  current Status; IE is bit 0, EXL is bit 1, IM is [15:8].
- cp0_cause  in  32  current Cause; IP is [15:8].
- cp0_epc  in  32  current EPC.
- cp0_exception_valid  out  1  one-cycle exception commit strobe to CP0.
- cp0_eret_flush  out  1  one-cycle ERET strobe to CP0.
- cp0_exception_code  out  5  latched code; valid while cp0_exception_valid is high.
- cp0_exception_address  out  32  latched wb_pc.
- cp0_in_delay_slot  out  1  latched wb_in_delay_slot.
- pipeline_flush  out  1  kill all instructions in IF..WB.
- redirect_valid  out  1  redirect_pc is valid.
- redirect_pc  out  32  fetch target.
- if_ready  in  1  IF accepts the redirect this cycle.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset values:
  - State is IDLE and the drain counter is 0.
  - All outputs are 0, including redirect_pc and the latched code, address and delay-slot fields.
  - Reset mid-sequence aborts at the next edge. No strobe is issued in that cycle.
- Interrupt pending: int_pend = IE & ~EXL & |(IM & IP), evaluated combinationally from the inputs.
- Event detection, IDLE only, qualified by wb_valid. Priority is interrupt > wb_exception_valid > wb_eret:
  - Interrupt: kind = EXC, code = INT_EXCEPTION_CODE. A simultaneous ERET or exception is suppressed.
  - wb_exception_valid: kind = EXC, code = wb_exception_code. A simultaneous wb_eret is ignored.
  - wb_eret alone: kind = ERET.
  - On any event, latch wb_pc and wb_in_delay_slot, then go to COMMIT.
- No wb_valid: no event, even when int_pend is high.
- Outside IDLE, all wb_* inputs are ignored. Those instructions are being flushed.
- COMMIT (1 cycle):
  - Assert cp0_exception_valid (EXC) or cp0_eret_flush (ERET); exactly one of them.
  - Assert pipeline_flush.
  - Load the drain counter with FLUSH_CYCLES-1, then go to DRAIN.
- DRAIN:
  - Assert pipeline_flush and decrement the counter each cycle.
  - Leave when counter == 0, giving exactly FLUSH_CYCLES cycles in DRAIN.
  - On the exit edge, latch redirect_pc = EXCEPTION_VECTOR (EXC) or cp0_epc (ERET). CP0 has already absorbed any earlier MTC0 EPC write by this point.
  - Go to REDIRECT.
- REDIRECT:
  - redirect_valid = 1 and redirect_pc is stable. pipeline_flush = 0.
  - Hold while if_ready = 0.
  - On if_ready = 1, the transfer completes that cycle and the next state is IDLE.
- Output timing:
  - redirect_valid and pipeline_flush are registered state decodes.
  - Strobes are high only in COMMIT.
  - busy = (state != IDLE).
- Latency: event cycle → COMMIT at +1 → first redirect_valid at +2+FLUSH_CYCLES.

Test Plan:
- Syscall exception (code 5'h08, wb_pc=32'hbfc00100, not in delay slot) → cp0_exception_valid high 1 cycle at +1 with code 8 and address 32'hbfc00100; pipeline_flush high for 3 cycles; redirect_valid at +4 with redirect_pc 32'hbfc00380.
- ERET with cp0_epc=32'hbfc00200, if_ready held 0 for 3 cycles → cp0_eret_flush pulse; redirect_valid held with 32'hbfc00200 for 4 cycles; IDLE after the if_ready cycle.
- Status=32'h0000_0401 (IE=1, IM[2]=1), Cause IP[2]=1, with wb_eret in the same cycle → EXC with code 0; no cp0_eret_flush.
- Same interrupt setup but EXL=1 or wb_valid=0 → no strobe; busy stays 0.
- Second exception presented in WB while busy → ignored; exactly one cp0_exception_valid pulse.
- reset asserted during DRAIN → next cycle all outputs 0 and state IDLE; a later exception is handled normally.
